// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - RV32I decode stage with register file and write-back bypass
//
// common_pkg : shared pipeline types (instruction, branch prediction, control bundle)
// decode_stage ports:
//   clk             in   rising-edge clock
//   reset_n         in   synchronous reset, asserted high (clears the register file)
//   instruction     in   fetched instruction
//   pc              in   PC of the instruction
//   write_en        in   write-back register write enable
//   write_id        in   write-back destination register
//   write_data      in   write-back data
//   branch_in       in   branch prediction info from fetch
//   branch_out      out  branch_in passed through
//   reg_rd_id       out  instruction rd field
//   pc_out          out  pc passed through
//   read_data1      out  register[rs1] (with write-back bypass)
//   read_data2      out  register[rs2] (with write-back bypass)
//   immediate_data  out  sign-extended immediate
//   control_signals out  control bundle for execute
//   debug_reg       out  stored register-file contents (no bypass)

package common_pkg;
  parameter int REGISTER_FILE_SIZE = 32;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } instruction_type;

  typedef struct packed {
    logic        predicted_taken;
    logic [31:0] predicted_target;
  } branch_predict_type;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       is_branch;
    logic       is_jump;
    logic       is_jalr;
    logic       is_lui;
    logic       is_auipc;
    logic [2:0] funct3;
  } control_type;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
endpackage

module decode_stage
  import common_pkg::*;
#(
  parameter int REGISTER_FILE_SIZE = common_pkg::REGISTER_FILE_SIZE
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  instruction_type                      instruction,
  input  logic [31:0]                          pc,
  input  logic                                 write_en,
  input  logic [4:0]                           write_id,
  input  logic [31:0]                          write_data,
  input  branch_predict_type                   branch_in,
  output branch_predict_type                   branch_out,
  output logic [4:0]                           reg_rd_id,
  output logic [31:0]                          pc_out,
  output logic [31:0]                          read_data1,
  output logic [31:0]                          read_data2,
  output logic [31:0]                          immediate_data,
  output control_type                          control_signals,
  output logic [REGISTER_FILE_SIZE-1:0][31:0]  debug_reg
);

  logic [31:0] r_regs [REGISTER_FILE_SIZE];
  logic [31:0] w_inst;
  logic        w_wb_valid;

  assign w_inst     = instruction;
  assign w_wb_valid = write_en && (write_id != 5'd0);

  assign branch_out = branch_in;
  assign reg_rd_id  = instruction.rd;
  assign pc_out     = pc;

  // Register file; reset_n is active high despite its name.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < REGISTER_FILE_SIZE; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_valid) begin
      r_regs[write_id] <= write_data;
    end
  end

  always_comb begin
    for (int i = 0; i < REGISTER_FILE_SIZE; i++) begin
      debug_reg[i] = (i == 0) ? 32'd0 : r_regs[i];
    end
  end

  // Bypass lets an instruction see the value being written back this cycle.
  always_comb begin
    read_data1 = '0;
    read_data2 = '0;
    if (instruction.rs1 != 5'd0) begin
      read_data1 = (w_wb_valid && write_id == instruction.rs1) ? write_data : r_regs[instruction.rs1];
    end
    if (instruction.rs2 != 5'd0) begin
      read_data2 = (w_wb_valid && write_id == instruction.rs2) ? write_data : r_regs[instruction.rs2];
    end
  end

  // funct7[5] selects SUB only for register-register ops; shifts use it in both forms.
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic alt, input logic is_reg);
    logic [3:0] op;
    case (f3)
      3'd0:    op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLT;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    control_signals = '0;
    immediate_data  = '0;
    case (instruction.opcode)
      OPC_OP: begin
        control_signals.alu_op    = arith_op(instruction.funct3, instruction.funct7[5], 1'b1);
        control_signals.reg_write = 1'b1;
      end
      OPC_OP_IMM: begin
        control_signals.alu_op    = arith_op(instruction.funct3, instruction.funct7[5], 1'b0);
        control_signals.alu_src   = 1'b1;
        control_signals.reg_write = 1'b1;
        immediate_data            = {{20{w_inst[31]}}, w_inst[31:20]};
      end
      OPC_LOAD: begin
        control_signals.alu_src    = 1'b1;
        control_signals.reg_write  = 1'b1;
        control_signals.mem_read   = 1'b1;
        control_signals.mem_to_reg = 1'b1;
        immediate_data             = {{20{w_inst[31]}}, w_inst[31:20]};
      end
      OPC_STORE: begin
        control_signals.alu_src   = 1'b1;
        control_signals.mem_write = 1'b1;
        immediate_data            = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
      end
      OPC_BRANCH: begin
        control_signals.alu_op    = ALU_SUB;
        control_signals.is_branch = 1'b1;
        immediate_data            = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
      end
      OPC_JAL: begin
        control_signals.alu_src   = 1'b1;
        control_signals.reg_write = 1'b1;
        control_signals.is_jump   = 1'b1;
        immediate_data            = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        control_signals.alu_src   = 1'b1;
        control_signals.reg_write = 1'b1;
        control_signals.is_jump   = 1'b1;
        control_signals.is_jalr   = 1'b1;
        immediate_data            = {{20{w_inst[31]}}, w_inst[31:20]};
      end
      OPC_LUI: begin
        control_signals.alu_op    = ALU_PASS_B;
        control_signals.alu_src   = 1'b1;
        control_signals.reg_write = 1'b1;
        control_signals.is_lui    = 1'b1;
        immediate_data            = {w_inst[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        control_signals.alu_src   = 1'b1;
        control_signals.reg_write = 1'b1;
        control_signals.is_auipc  = 1'b1;
        immediate_data            = {w_inst[31:12], 12'd0};
      end
      default: begin
      end
    endcase
    // Unknown opcodes (including the all-zero bubble) leave the whole bundle zero, funct3 too.
    if (control_signals != '0 || instruction.opcode == OPC_BRANCH || instruction.opcode == OPC_OP
        || instruction.opcode == OPC_STORE) begin
      control_signals.funct3 = instruction.funct3;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// tb/tb_decode_stage.sv - randomized self-checking bench for decode_stage
module tb_decode_stage;
  import common_pkg::*;

  localparam int K_R = 0, K_I = 1, K_LOAD = 2, K_STORE = 3, K_BR = 4, K_JAL = 5,
                 K_JALR = 6, K_LUI = 7, K_AUIPC = 8, K_UNK = 9;

  logic                 clk = 0;
  logic                 reset_n;
  instruction_type      instruction;
  logic [31:0]          pc;
  logic                 write_en;
  logic [4:0]           write_id;
  logic [31:0]          write_data;
  branch_predict_type   branch_in, branch_out;
  logic [4:0]           reg_rd_id;
  logic [31:0]          pc_out, read_data1, read_data2, immediate_data;
  control_type          control_signals;
  logic [31:0][31:0]    debug_reg;

  int checks = 0;
  int failures = 0;
  bit chk_en = 0;
  logic [31:0] model [32];
  branch_predict_type bp;

  decode_stage dut (
    .clk(clk), .reset_n(reset_n), .instruction(instruction), .pc(pc),
    .write_en(write_en), .write_id(write_id), .write_data(write_data),
    .branch_in(branch_in), .branch_out(branch_out), .reg_rd_id(reg_rd_id),
    .pc_out(pc_out), .read_data1(read_data1), .read_data2(read_data2),
    .immediate_data(immediate_data), .control_signals(control_signals),
    .debug_reg(debug_reg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int kind_of(input logic [6:0] opc);
    case (opc)
      7'b0110011: return K_R;
      7'b0010011: return K_I;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_UNK;
    endcase
  endfunction

  function automatic logic [31:0] exp_imm(input logic [31:0] ins);
    int k;
    int v;
    k = kind_of(ins[6:0]);
    case (k)
      K_I, K_LOAD, K_JALR: v = $signed(ins) >>> 20;
      K_STORE: v = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
      K_BR: v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2 - int'(ins[31]) * 4096;
      K_JAL: v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2 - int'(ins[31]) * (1 << 20);
      K_LUI, K_AUIPC: v = int'(ins & 32'hFFFF_F000);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic control_type exp_ctrl(input logic [31:0] ins);
    control_type c;
    int k;
    int base [8];
    int op;
    base = '{0, 2, 3, 4, 5, 6, 8, 9};
    k = kind_of(ins[6:0]);
    c = '0;
    if (k == K_UNK) return c;
    op = 0;
    if (k == K_R || k == K_I) begin
      op = base[ins[14:12]];
      if (ins[14:12] == 3'd5 && ins[30]) op = 7;
      if (ins[14:12] == 3'd0 && ins[30] && k == K_R) op = 1;
    end else if (k == K_BR) op = 1;
    else if (k == K_LUI) op = 10;
    c.alu_op     = 4'(op);
    c.alu_src    = !(k inside {K_R, K_BR});
    c.reg_write  = k inside {K_R, K_I, K_LOAD, K_JAL, K_JALR, K_LUI, K_AUIPC};
    c.mem_read   = (k == K_LOAD);
    c.mem_to_reg = (k == K_LOAD);
    c.mem_write  = (k == K_STORE);
    c.is_branch  = (k == K_BR);
    c.is_jump    = (k == K_JAL || k == K_JALR);
    c.is_jalr    = (k == K_JALR);
    c.is_lui     = (k == K_LUI);
    c.is_auipc   = (k == K_AUIPC);
    c.funct3     = ins[14:12];
    return c;
  endfunction

  function automatic logic [31:0] exp_read(input logic [4:0] id);
    if (id == 0) return 32'd0;
    if (write_en && write_id == id) return write_data;
    return model[id];
  endfunction

  always @(posedge clk) begin
    if (reset_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'd0;
    end else if (write_en && write_id != 0) begin
      model[write_id] = write_data;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      int idx;
      idx = 0;
      for (int i = 31; i >= 0; i--) if (debug_reg[i] !== model[i]) idx = i;
      chk("imm", immediate_data, exp_imm(instruction));
      chk("ctrl", 32'(control_signals), 32'(exp_ctrl(instruction)));
      chk("rd1", read_data1, exp_read(instruction.rs1));
      chk("rd2", read_data2, exp_read(instruction.rs2));
      chk("rd_id", 32'(reg_rd_id), 32'(instruction[11:7]));
      chk("pc_out", pc_out, pc);
      chk("br_out", 32'(branch_out.predicted_target ^ {31'd0, branch_out.predicted_taken}),
          32'(branch_in.predicted_target ^ {31'd0, branch_in.predicted_taken}));
      chk($sformatf("debug_reg[%0d]", idx), debug_reg[idx], model[idx]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  initial begin
    control_type c;
    logic [31:0] ins;
    logic [6:0] opcs [9];
    opcs = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    reset_n = 1; instruction = '0; pc = '0; write_en = 0; write_id = 0; write_data = 0;
    branch_in = '0; bp = '0;
    step(); step();
    reset_n = 0; chk_en = 1;
    at_neg();
    chk("reset_all_zero", 32'(debug_reg == '0), 32'd1);

    write_en = 1; write_id = 5; write_data = 32'h0000_DEAD;
    step();
    write_en = 0;
    at_neg();
    chk("x5_written", debug_reg[5], 32'h0000_DEAD);
    step(); reset_n = 1;
    step(); reset_n = 0;
    at_neg();
    chk("x5_after_reset", debug_reg[5], 32'd0);
    chk("all_after_reset", 32'(debug_reg == '0), 32'd1);

    step(); write_en = 1; write_id = 3; write_data = 32'h0000_1234;
    step(); write_en = 0; instruction = 32'h0001_8093;
    at_neg();
    chk("lit_rd1_x3", read_data1, 32'h0000_1234);
    chk("lit_dbg_x3", debug_reg[3], 32'h0000_1234);

    step(); write_en = 1; write_id = 0; write_data = 32'hFFFF_FFFF; instruction = 32'h0000_0093;
    at_neg();
    chk("lit_x0_read", read_data1, 32'd0);
    step(); write_en = 1; write_id = 7; write_data = 32'hA5A5_A5A5; instruction = 32'h0070_00B3;
    at_neg();
    chk("lit_x0_stays", debug_reg[0], 32'd0);
    chk("lit_bypass_rd2", read_data2, 32'hA5A5_A5A5);
    chk("lit_no_dbg_bypass", debug_reg[7], 32'd0);

    step(); write_en = 0; instruction = 32'hFFF0_0293;
    at_neg();
    c = control_signals;
    chk("lit_addi_imm", immediate_data, 32'hFFFF_FFFF);
    chk("lit_addi_rd", 32'(reg_rd_id), 32'd5);
    chk("lit_addi_flags", {c.alu_op, c.alu_src, c.reg_write, c.mem_read}, {4'd0, 1'b1, 1'b1, 1'b0});

    step(); instruction = 32'hFE20_8CE3; pc = 32'h100;
    bp.predicted_taken = 1'b1; bp.predicted_target = $urandom; branch_in = bp;
    at_neg();
    c = control_signals;
    chk("lit_beq_imm", immediate_data, 32'hFFFF_FFF8);
    chk("lit_beq_flags", {c.is_branch, c.alu_op, c.reg_write}, {1'b1, 4'd1, 1'b0});
    chk("lit_beq_pc", pc_out, 32'h100);
    chk("lit_beq_bp", branch_out.predicted_target, bp.predicted_target);

    step(); instruction = 32'h1234_54B7;
    at_neg();
    c = control_signals;
    chk("lit_lui_imm", immediate_data, 32'h1234_5000);
    chk("lit_lui_flags", {c.is_lui, c.alu_op}, {1'b1, 4'd10});

    step(); instruction = 32'h0;
    at_neg();
    chk("lit_bubble_ctrl", 32'(control_signals), 32'd0);
    chk("lit_bubble_imm", immediate_data, 32'd0);

    for (int n = 0; n < 3000; n++) begin
      step();
      ins = $urandom;
      if ($urandom_range(7) != 0) ins[6:0] = opcs[$urandom_range(8)];
      instruction = ins;
      pc = $urandom;
      branch_in.predicted_taken = 1'($urandom);
      branch_in.predicted_target = $urandom;
      reset_n = ($urandom_range(60) == 0);
      write_en = 1'($urandom);
      case ($urandom_range(3))
        0: write_id = ins[19:15];
        1: write_id = ins[24:20];
        default: write_id = 5'($urandom);
      endcase
      write_data = $urandom;
    end
    step();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- RV32I instruction-decode stage of the in-order RISC-V pipeline. Sits between fetch and execute.
- Cracks the fetched instruction into register operands, a sign-extended immediate and a control bundle.
- Owns the 32x32 architectural register file, which is written back by the write-back stage.
- Passes PC and branch-prediction info through unchanged.

Parameters:
- REGISTER_FILE_SIZE, 32, number of architectural registers (from common package); x0 hardwired to zero.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  synchronous, active-high reset (name kept from codebase; asserted = 1).
- instruction  input  32 (instruction_type)  fields funct7[31:25], rs2[24:20], rs1[19:15], funct3[14:12], rd[11:7], opcode[6:0].
- pc  input  32  PC of the instruction.
- write_en  input  1  register-file write enable from write-back.
- write_id  input  5  write-back destination register.
- write_data  input  32  write-back data.
- branch_in  input  branch_predict_type  prediction info from fetch.
- branch_out  output  branch_predict_type  equals branch_in.
- reg_rd_id  output  5  instruction[11:7].
- pc_out  output  32  equals pc.
- read_data1  output  32  register[rs1].
- read_data2  output  32  register[rs2].
- immediate_data  output  32  sign-extended immediate.
- control_signals  output  control_type  fields: alu_op[3:0], alu_src, mem_read, mem_write, reg_write, mem_to_reg, is_branch, is_jump, is_jalr, is_lui, is_auipc, funct3[2:0].
- debug_reg  output  32 x REGISTER_FILE_SIZE  live register-file contents.

Behaviour:
- Decode is purely combinational. All outputs except debug_reg settle within the cycle the instruction is presented. No handshake; every cycle decodes a new instruction.
- Register file:
  - On a rising clk edge with reset_n=1, all registers are cleared to 0.
  - Otherwise, when write_en=1 and write_id!=0, register[write_id] <= write_data.
  - Writes to x0 are ignored; x0 always reads 0.
- Read bypass: if write_en=1, write_id!=0 and write_id equals rs1 (resp. rs2), read_data1 (resp. read_data2) returns write_data in the same cycle. debug_reg shows stored values only, with no bypass.
- Reset: while reset_n=1 the combinational outputs still follow the inputs. debug_reg reads all zero from the edge after reset is sampled.
- Immediates:
  - I-type (OP-IMM 0010011, LOAD 0000011, JALR 1100111): sext(inst[31:20]).
  - S-type (STORE 0100011): sext({inst[31:25], inst[11:7]}).
  - B-type (BRANCH 1100011): sext({inst[31], inst[7], inst[30:25], inst[11:8], 0}).
  - U-type (LUI 0110111, AUIPC 0010111): {inst[31:12], 12'b0}.
  - J-type (JAL 1101111): sext({inst[31], inst[19:12], inst[20], inst[30:21], 0}).
  - R-type and unknown opcodes: 0.
- alu_op encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10.
  - R-type: selected from funct3, with funct7[5] choosing SUB vs ADD and SRA vs SRL.
  - OP-IMM: same selection, except funct7[5] is used only for shifts (ADDI is never SUB).
  - LOAD, STORE, JAL, JALR, AUIPC: ADD.
  - BRANCH: SUB.
  - LUI: PASS_B.
- Control flags:
  - alu_src=1 for every type except R and BRANCH.
  - reg_write=1 for R, OP-IMM, LOAD, JAL, JALR, LUI, AUIPC.
  - mem_read=mem_to_reg=1 for LOAD only.
  - mem_write=1 for STORE only.
  - is_branch=1 for BRANCH; is_jump=1 for JAL and JALR; is_jalr=1 for JALR; is_lui=1 for LUI; is_auipc=1 for AUIPC.
  - funct3 = inst[14:12] always.
- Unknown opcode (including all-zero bubble): all control fields 0, immediate 0. Register reads still performed.
- reg_rd_id, pc_out and branch_out are always raw pass-throughs, regardless of opcode.

Test Plan:
- Reset: assert reset_n=1 for one cycle after writing x5=0xDEAD -> debug_reg[5]=0 and all debug_reg=0.
- Write/read: write_en=1, write_id=3, write_data=0x00001234, one edge; then instruction rs1=3 -> read_data1=0x00001234, debug_reg[3]=0x1234.
- x0 and bypass: write x0=0xFFFFFFFF -> read x0=0. In the same cycle, write x7=0xA5A5A5A5 with rs2=7 -> read_data2=0xA5A5A5A5 before the edge.
- addi x5,x0,-1 (0xFFF00293) -> immediate_data=0xFFFFFFFF, reg_rd_id=5, alu_op=0, alu_src=1, reg_write=1, mem_read=0.
- beq x1,x2,-8 (0xFE208CE3) with pc=0x100 and branch_in=X -> immediate_data=0xFFFFFFF8, is_branch=1, alu_op=1, reg_write=0, pc_out=0x100, branch_out=X.
- lui x9,0x12345 (0x123454B7) -> immediate_data=0x12345000, is_lui=1, alu_op=10. Instruction 0x00000000 -> all control fields 0.
